data_memory_responder: RTL and testbench

- Main-memory responder on the far side of the data cache's line-fill and write-back interface.
- Accepts 256-bit line read and write requests (enable, write, address, data) and returns a one-cycle ack after a fixed latency.
- On a read, returns the addressed line with the ack.
- Sits at the top level beside the CPU and drives the CPU's memory ack and read-data inputs.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_line_ram.sv | 27 ++
 rtl/data_memory_responder.sv | 153 +++++++++++++++
 tb/tb_data_memory_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, line
// geometry and the latency counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int LINE_BITS   = 256;
    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = 5;

    // LATENCY may be as large as 255, so an 8-bit down-counter covers it.
    localparam int CNT_BITS    = 8;

endpackage

// File: rtl/dmem_line_ram.sv
// Line storage for the data-memory responder: one 256-bit line per index,
// written on the clock edge and read combinationally. The array has no reset,
// so its contents survive a responder reset.
module dmem_line_ram
    import dmem_pkg::*;
#(
    parameter int IDX_BITS = 9
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [IDX_BITS-1:0]  idx_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem [2**IDX_BITS];

    // Store the presented line at the end of any cycle with the write strobe high.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/data_memory_responder.sv
// Main-memory responder for the data cache's line-fill / write-back port.
// A request is latched on acceptance, a down-counter models the fixed access
// latency, and a one-cycle registered ack (with read data) is returned.
// The ACK state is the final internal cycle; ack_o and data_o are loaded on the
// edge that leaves it, so the requester sees ack exactly LATENCY cycles after
// acceptance, and a request still held high during that ack cycle is accepted
// on the following edge (acks spaced LATENCY+1 apart).
// Optional: define DMEM_PROTOCOL_CHECK_EN to add the sticky err_o flag that
// records requester changes while a transaction is waiting.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int LINE_IDX_BITS = 9,
    parameter int LATENCY       = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
`ifdef DMEM_PROTOCOL_CHECK_EN
    ,
    output logic                 err_o
`endif
);

    state_e                   state_q, state_d;
    logic [CNT_BITS-1:0]      count_q, count_d;
    logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
    logic                     write_q, write_d;
    logic [LINE_BITS-1:0]     wdata_q, wdata_d;
    logic [LINE_BITS-1:0]     rdata_q, rdata_d;
    logic                     ack_q, ack_d;
    logic                     ram_we;
    logic [LINE_BITS-1:0]     ram_rdata;

    // Offset bits and bits above the line index do not select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:LINE_IDX_BITS+OFFSET_BITS], addr_i[OFFSET_BITS-1:0]};

    dmem_line_ram #(
        .IDX_BITS (LINE_IDX_BITS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Next-state logic: accept in IDLE, count down in WAIT, complete in ACK.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[LINE_IDX_BITS+OFFSET_BITS-1:OFFSET_BITS];
                    write_d = write_i;
                    wdata_d = data_i;
                    count_d = CNT_BITS'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - CNT_BITS'(1);
                if (count_q == CNT_BITS'(1)) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d   = 1'b1;
                ram_we  = write_q;
                if (!write_q) begin
                    rdata_d = ram_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic [31:OFFSET_BITS] tag_q, tag_d;
    logic                  err_q, err_d;

    // Flag any requester change (drop, new line address, new direction) while waiting.
    always_comb begin
        tag_d = tag_q;
        err_d = err_q;
        if (state_q == IDLE && enable_i) begin
            tag_d = addr_i[31:OFFSET_BITS];
        end
        if (state_q == WAIT &&
            (!enable_i || addr_i[31:OFFSET_BITS] != tag_q || write_i != write_q)) begin
            err_d = 1'b1;
        end
    end

    // Full line address for comparison and the sticky error flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tag_q <= '0;
            err_q <= 1'b0;
        end else begin
            tag_q <= tag_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder. Two instances share the clock
// and reset: unit 0 with the default LATENCY=10, unit 1 with LATENCY=1. The
// reference model is a sparse map of line contents keyed by line index, plus
// the last value each unit returned on a read.
module tb_data_memory_responder;

    localparam int PERIOD = 10;

    logic         clk = 1'b0;
    logic         rstN;
    logic         en    [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [255:0] wdata [2];
    logic         ack   [2];
    logic [255:0] rdata [2];
`ifdef DMEM_PROTOCOL_CHECK_EN
    logic         err   [2];
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: line contents per (unit, index) and each unit's last read data.
    logic [255:0] lineModel [int];
    logic [255:0] lastRead  [2];
    bit           lastKnown [2];
    int           latency   [2];

    always #(PERIOD/2) clk = ~clk;

    data_memory_responder #(
        .LINE_IDX_BITS (9),
        .LATENCY       (10)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rstN),
        .enable_i (en[0]),
        .write_i  (wr[0]),
        .addr_i   (addr[0]),
        .data_i   (wdata[0]),
        .ack_o    (ack[0]),
        .data_o   (rdata[0])
`ifdef DMEM_PROTOCOL_CHECK_EN
        ,
        .err_o    (err[0])
`endif
    );

    data_memory_responder #(
        .LINE_IDX_BITS (9),
        .LATENCY       (1)
    ) dutFast (
        .clk_i    (clk),
        .rst_i    (rstN),
        .enable_i (en[1]),
        .write_i  (wr[1]),
        .addr_i   (addr[1]),
        .data_i   (wdata[1]),
        .ack_o    (ack[1]),
        .data_o   (rdata[1])
`ifdef DMEM_PROTOCOL_CHECK_EN
        ,
        .err_o    (err[1])
`endif
    );

    // Memory holds 512 lines of 32 bytes; everything else in the address aliases.
    function automatic int lineKey(input int unit, input logic [31:0] a);
        return unit * 4096 + int'((a / 32) % 512);
    endfunction

    function automatic logic [255:0] randLine();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one transaction on a unit: present it at a falling edge, wait for the
    // ack with a bounded cycle count, check latency and data, update the model.
    // With keep set, enable stays high so the next call starts back-to-back.
    task automatic applyStimulus(input int unit, input logic isWrite, input logic [31:0] a,
                                 input logic [255:0] d, input bit keep, output time ackTime);
        int           n;
        bit           got;
        int           key;
        bit           expKnown;
        logic [255:0] expData;
        @(negedge clk);
        en[unit]    = 1'b1;
        wr[unit]    = isWrite;
        addr[unit]  = a;
        wdata[unit] = d;
        key = lineKey(unit, a);
        if (isWrite) begin
            expKnown = lastKnown[unit];
            expData  = lastRead[unit];
        end else begin
            expKnown = (lineModel.exists(key) != 0);
            expData  = expKnown ? lineModel[key] : '0;
        end
        @(posedge clk);
        n   = 0;
        got = 0;
        while (!got && n < latency[unit] + 8) begin
            @(posedge clk);
            #1;
            n++;
            if (ack[unit] === 1'b1) got = 1;
        end
        ackTime = $time;
        checkOutput(isWrite ? "write_ack_latency" : "read_ack_latency", 256'(n), 256'(latency[unit]));
        if (got && expKnown) begin
            checkOutput(isWrite ? "data_held_on_write_ack" : "read_data", rdata[unit], expData);
        end
        if (isWrite) begin
            lineModel[key] = d;
        end else begin
            lastRead[unit]  = expData;
            lastKnown[unit] = expKnown;
        end
        if (!keep) begin
            @(negedge clk);
            en[unit] = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("ack_single_pulse", 256'(ack[unit]), 256'(0));
        end
    endtask

    // Hard stop in case something wedges the sequence below.
    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence followed by randomized traffic, then the summary.
    initial begin
        time          t0, t1, t2, t3;
        logic [255:0] patA, patB, prior, line40;
        bit           sawAck;

        latency[0] = 10;
        latency[1] = 1;
        for (int u = 0; u < 2; u++) begin
            en[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
            lastRead[u] = '0; lastKnown[u] = 1'b1;
        end
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ack0", 256'(ack[0]), 256'(0));
        checkOutput("reset_data0", rdata[0], '0);
        checkOutput("reset_ack1", 256'(ack[1]), 256'(0));
        checkOutput("reset_data1", rdata[1], '0);
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] preload line 0x40 and read it back");
        applyStimulus(0, 1'b1, 32'h0000_0040, {32{8'hA5}}, 0, t0);
        applyStimulus(0, 1'b0, 32'h0000_0040, '0, 0, t0);

        $display("[TB] write 0x100, read 0x11F (offset ignored)");
        patA = {8{32'h1234_5678}} ^ {4{64'h0F0F_0000_F0F0_FFFF}};
        applyStimulus(0, 1'b1, 32'h0000_0100, patA, 0, t0);
        applyStimulus(0, 1'b0, 32'h0000_011F, '0, 0, t0);

        $display("[TB] back-to-back write/read to 0x80 with enable held");
        patA = randLine();
        patB = randLine();
        applyStimulus(0, 1'b1, 32'h0000_0080, patA, 1, t0);
        applyStimulus(0, 1'b0, 32'h0000_0080, '0, 1, t1);
        applyStimulus(0, 1'b1, 32'h0000_0080, patB, 1, t2);
        applyStimulus(0, 1'b0, 32'h0000_0080, '0, 0, t3);
        checkOutput("b2b_spacing_1", 256'((t1 - t0) / PERIOD), 256'(11));
        checkOutput("b2b_spacing_2", 256'((t2 - t1) / PERIOD), 256'(11));
        checkOutput("b2b_spacing_3", 256'((t3 - t2) / PERIOD), 256'(11));

        $display("[TB] reset 4 cycles into a write to 0x200");
        prior = randLine();
        applyStimulus(0, 1'b1, 32'h0000_0200, prior, 0, t0);
        @(negedge clk);
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0200; wdata[0] = ~prior;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rstN  = 1'b0;
        en[0] = 1'b0;
        #1;
        checkOutput("abort_reset_data", rdata[0], '0);
        lastRead[0] = '0; lastRead[1] = '0;
        lastKnown[0] = 1'b1; lastKnown[1] = 1'b1;
        @(negedge clk);
        rstN   = 1'b1;
        sawAck = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ack[0] !== 1'b0) sawAck = 1;
        end
        checkOutput("no_ack_after_abort", 256'(sawAck), 256'(0));
        applyStimulus(0, 1'b0, 32'h0000_0200, '0, 0, t0);

        $display("[TB] randomized traffic over lines at 0x1000");
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            bit          doWrite;
            bit          keep;
            a = ($urandom & 32'hFFFF_C000) | (32'h1000 + 32'($urandom_range(0, 7)) * 32)
                | 32'($urandom_range(0, 31));
            doWrite = ($urandom_range(0, 1) == 1) || (lineModel.exists(lineKey(0, a)) == 0);
            keep    = (i < 23) ? ($urandom_range(0, 1) == 1) : 1'b0;
            applyStimulus(0, doWrite, a, randLine(), keep, t0);
        end

        $display("[TB] LATENCY=1 unit: aliasing and back-to-back");
        patA = randLine();
        applyStimulus(1, 1'b1, 32'h0000_0040, patA, 0, t0);
        applyStimulus(1, 1'b0, 32'h0000_4040, '0, 0, t0);
        applyStimulus(1, 1'b1, 32'h0000_0060, patB, 1, t1);
        applyStimulus(1, 1'b0, 32'h0000_0060, '0, 0, t2);
        checkOutput("fast_b2b_spacing", 256'((t2 - t1) / PERIOD), 256'(2));

`ifdef DMEM_PROTOCOL_CHECK_EN
        $display("[TB] protocol check: address change during WAIT");
        checkOutput("err_clear_before", 256'(err[0]), 256'(0));
        line40 = lineModel[lineKey(0, 32'h40)];
        @(negedge clk);
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0040;
        @(posedge clk);
        @(negedge clk);
        addr[0] = 32'h0000_0060;
        sawAck = 0;
        for (int i = 0; i < 18 && !sawAck; i++) begin
            @(posedge clk);
            #1;
            if (ack[0] === 1'b1) sawAck = 1;
        end
        checkOutput("err_ack_still_issued", 256'(sawAck), 256'(1));
        checkOutput("err_read_data_line40", rdata[0], line40);
        checkOutput("err_set", 256'(err[0]), 256'(1));
        @(negedge clk);
        en[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_sticky", 256'(err[0]), 256'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
